// File: rtl/adc_frame_packer.sv
// adc_frame_packer: buffers one ADC sample and serialises it as a 4-byte
// frame (header, sample high byte, sample low byte, XOR checksum) toward a
// UART transmitter. Each byte is paced by a 0->1 edge on eot_i. A per-byte
// watchdog aborts the frame when the transmitter stalls.

module adc_frame_packer #(
    parameter int                 DataWidth = 12,
    parameter logic [7:0]         Header    = 8'hA5,
    parameter int                 ToWidth   = 20,
    parameter logic [ToWidth-1:0] ToLimit   = 20'hFFFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic [DataWidth-1:0] sample_i,
    input  logic                 valid_i,
    input  logic                 clr_i,
    input  logic                 eot_i,
    output logic [7:0]           d_o,
    output logic                 st_o,
    output logic                 busy_o,
    output logic                 ovf_o,
    output logic                 to_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    localparam logic [1:0]         LastIdx  = 2'd3;
    localparam logic [ToWidth-1:0] WdOne    = {{(ToWidth-1){1'b0}}, 1'b1};
    localparam logic [ToWidth-1:0] WdFinal  = ToLimit - WdOne;

    // FSM state and frame bookkeeping
    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic [ToWidth-1:0]  wd_q, wd_d;
    logic [15:0]         frame_q, frame_d;
    logic [7:0]          d_q, d_d;

    // One-entry sample buffer
    logic                buf_full_q, buf_full_d;
    logic [15:0]         buf_data_q, buf_data_d;

    // Sticky status flags
    logic                ovf_q, ovf_d;
    logic                to_q, to_d;

    // Previous eot_i value for edge detection
    logic                eot_q;

    // Internal handshakes between the FSM and the buffer/flags
    logic                take;
    logic                drop;
    logic                timeout;
    logic                eot_rise;
    logic [15:0]         sample_ext;
    logic [7:0]          cur_byte;

    assign sample_ext = 16'(sample_i);
    assign eot_rise   = eot_i & ~eot_q;

    // Select the frame byte addressed by the byte index
    always_comb begin
        // NOTE: every signal assigned in an always_comb gets a default (or a
        // full case) so no path leaves it unassigned and no latch is inferred.
        cur_byte = Header;
        unique case (idx_q)
            2'd0: cur_byte = Header;
            2'd1: cur_byte = frame_q[15:8];
            2'd2: cur_byte = frame_q[7:0];
            2'd3: cur_byte = Header ^ frame_q[15:8] ^ frame_q[7:0];
            default: cur_byte = Header;
        endcase
    end

    // Next-state logic of the frame sequencer
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wd_d    = wd_q;
        frame_d = frame_q;
        d_d     = d_q;
        take    = 1'b0;
        timeout = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // en_i only gates new frames; a held sample waits here.
                if (en_i && buf_full_q) begin
                    take    = 1'b1;
                    frame_d = buf_data_q;
                    idx_d   = 2'd0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                d_d     = cur_byte;
                wd_d    = '0;
                state_d = S_START;
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A byte-done edge beats a watchdog expiry in the same cycle.
                if (eot_rise) begin
                    if (idx_q == LastIdx) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else if (wd_q >= WdFinal) begin
                    timeout = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_d = wd_q + WdOne;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Buffer capture/drop: a slot being emptied this cycle may be refilled
    always_comb begin
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        drop       = 1'b0;

        if (take) begin
            buf_full_d = 1'b0;
        end

        if (valid_i) begin
            if (!buf_full_q || take) begin
                buf_full_d = 1'b1;
                buf_data_d = sample_ext;
            end else begin
                drop = 1'b1;
            end
        end
    end

    // Sticky flags: a set event in the same cycle as clr_i wins
    always_comb begin
        ovf_d = ovf_q;
        to_d  = to_q;

        if (clr_i) begin
            ovf_d = 1'b0;
            to_d  = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (timeout) begin
            to_d = 1'b1;
        end
    end

    // FSM and frame registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            wd_q    <= '0;
            frame_q <= 16'h0000;
            d_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wd_q    <= wd_d;
            frame_q <= frame_d;
            d_q     <= d_d;
        end
    end

    // Sample buffer registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            buf_full_q <= 1'b0;
            buf_data_q <= 16'h0000;
        end else begin
            buf_full_q <= buf_full_d;
            buf_data_q <= buf_data_d;
        end
    end

    // Sticky flag registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            to_q  <= to_d;
        end
    end

    // eot_i history; resets high so an eot_i already high is not an edge
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            eot_q <= 1'b1;
        end else begin
            eot_q <= eot_i;
        end
    end

    assign d_o    = d_q;
    assign st_o   = (state_q == S_START);
    assign busy_o = (state_q != S_IDLE);
    assign ovf_o  = ovf_q;
    assign to_o   = to_q;

endmodule
